// File: rtl/food_spawner_pkg.sv
// Shared defaults and FSM encoding for the food spawner and the grid cursor.
package food_pkg;

    localparam int GRID_W_DEF    = 40;
    localparam int GRID_H_DEF    = 30;
    localparam int XW_DEF        = 6;
    localparam int YW_DEF        = 5;
    localparam int MAX_TRIES_DEF = 8;

    typedef enum logic [2:0] {
        IDLE,
        SAMPLE,
        QUERY,
        SCAN_STEP,
        SCAN_QUERY
    } state_t;

endpackage

// File: rtl/food_spawner_if.sv
// Occupancy lookup handshake between the spawner and the snake body store.
interface food_spawner_if #(
    parameter int XW = 6,
    parameter int YW = 5
) ();
    logic          occ_req;
    logic [XW-1:0] occ_x;
    logic [YW-1:0] occ_y;
    logic          occ_ack;
    logic          occ_hit;

    modport master (
        output occ_req, occ_x, occ_y,
        input  occ_ack, occ_hit
    );

    modport slave (
        input  occ_req, occ_x, occ_y,
        output occ_ack, occ_hit
    );
endinterface

// File: rtl/food_spawner_grid_cursor.sv
// Registered grid coordinate with parallel load and raster-order wrap increment.
module grid_cursor
    import food_pkg::*;
#(
    parameter int W  = GRID_W_DEF,
    parameter int H  = GRID_H_DEF,
    parameter int XW = XW_DEF,
    parameter int YW = YW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [XW-1:0] load_x,
    input  logic [YW-1:0] load_y,
    input  logic          step,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y
);
    localparam logic [XW-1:0] X_LAST = XW'(W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(H - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            x <= '0;
            y <= '0;
        end else if (load) begin
            x <= load_x;
            y <= load_y;
        end else if (step) begin
            if (x == X_LAST) begin
                x <= '0;
                y <= (y == Y_LAST) ? '0 : y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end
endmodule

// File: rtl/food_spawner.sv
// Picks a free food cell: random PRNG candidates first, then a raster scan
// fallback after MAX_TRIES occupied hits so the search always terminates.
module food_spawner
    import food_pkg::*;
#(
    parameter int GRID_W    = GRID_W_DEF,
    parameter int GRID_H    = GRID_H_DEF,
    parameter int XW        = XW_DEF,
    parameter int YW        = YW_DEF,
    parameter int MAX_TRIES = MAX_TRIES_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 spawn_req,
    input  logic [15:0]          prng_in,
    food_spawner_if.master       occ,
    output logic [XW-1:0]        food_x,
    output logic [YW-1:0]        food_y,
    output logic                 food_valid,
    output logic                 busy,
    output logic                 done,
    output logic                 board_full
);
    localparam int CELLS = GRID_W * GRID_H;
    localparam int SW    = $clog2(CELLS);
    localparam int TW    = $clog2(MAX_TRIES + 1);

    localparam logic [XW-1:0] X_LAST    = XW'(GRID_W - 1);
    localparam logic [YW-1:0] Y_LAST    = YW'(GRID_H - 1);
    localparam logic [TW-1:0] T_LAST    = TW'(MAX_TRIES - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(CELLS - 1);

    state_t        state, state_next;
    logic [TW-1:0] tries;
    logic [SW-1:0] scan_cnt;
    logic [XW-1:0] cand_x, cur_x;
    logic [YW-1:0] cand_y, cur_y;
    logic          cand_ok;
    logic          commit, rand_hit, scan_hit;

    assign cand_x  = prng_in[XW-1:0];
    assign cand_y  = prng_in[XW+YW-1:XW];
    assign cand_ok = (cand_x <= X_LAST) && (cand_y <= Y_LAST);

    generate
        if (XW + YW < 16) begin : g_spare
            logic unused_prng;
            assign unused_prng = ^prng_in[15:XW+YW];
        end
    endgenerate

    // Handshake outcomes; occ_ack only matters while a query is outstanding.
    assign commit   = (state == QUERY || state == SCAN_QUERY) && occ.occ_ack && !occ.occ_hit;
    assign rand_hit = (state == QUERY) && occ.occ_ack && occ.occ_hit;
    assign scan_hit = (state == SCAN_QUERY) && occ.occ_ack && occ.occ_hit;

    grid_cursor #(
        .W  (GRID_W),
        .H  (GRID_H),
        .XW (XW),
        .YW (YW)
    ) u_cursor (
        .clk    (clk),
        .rst    (rst),
        .load   ((state == SAMPLE) && cand_ok),
        .load_x (cand_x),
        .load_y (cand_y),
        .step   (state == SCAN_STEP),
        .x      (cur_x),
        .y      (cur_y)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:       if (spawn_req) state_next = SAMPLE;
            SAMPLE:     if (cand_ok) state_next = QUERY;
            QUERY: begin
                if (occ.occ_ack) begin
                    if (!occ.occ_hit)        state_next = IDLE;
                    else if (tries == T_LAST) state_next = SCAN_STEP;
                    else                      state_next = SAMPLE;
                end
            end
            SCAN_STEP:  state_next = SCAN_QUERY;
            SCAN_QUERY: begin
                if (occ.occ_ack) begin
                    if (!occ.occ_hit)              state_next = IDLE;
                    else if (scan_cnt == SCAN_LAST) state_next = IDLE;
                    else                            state_next = SCAN_STEP;
                end
            end
            default:    state_next = IDLE;
        endcase
    end

    always_comb begin
        occ.occ_req = (state == QUERY) || (state == SCAN_QUERY);
        occ.occ_x   = cur_x;
        occ.occ_y   = cur_y;
        busy        = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tries      <= '0;
            scan_cnt   <= '0;
            food_x     <= '0;
            food_y     <= '0;
            food_valid <= 1'b0;
            done       <= 1'b0;
            board_full <= 1'b0;
        end else begin
            done       <= commit;
            board_full <= scan_hit && (scan_cnt == SCAN_LAST);
            if ((state == IDLE) && spawn_req) begin
                tries      <= '0;
                food_valid <= 1'b0;
            end
            if (rand_hit) begin
                tries <= tries + 1'b1;
                if (tries == T_LAST) scan_cnt <= '0;
            end
            if (scan_hit) scan_cnt <= scan_cnt + 1'b1;
            if (commit) begin
                food_x     <= cur_x;
                food_y     <= cur_y;
                food_valid <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_food_spawner.sv
// Scoreboard bench: a list-level model predicts every occupancy query and the final outcome.
module tb_food_spawner;
    typedef struct { int x; int y; } qry_t;
    typedef struct { bit full; int x; int y; } res_t;

    logic        clk, rst, start, noise_spawn, spawn_req;
    logic [15:0] prng_in;
    logic [5:0]  food_x;
    logic [4:0]  food_y;
    logic        food_valid, busy, done, board_full;

    food_spawner_if #(.XW(6), .YW(5)) occ ();

    food_spawner #(
        .GRID_W    (40),
        .GRID_H    (30),
        .XW        (6),
        .YW        (5),
        .MAX_TRIES (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .spawn_req  (spawn_req),
        .prng_in    (prng_in),
        .occ        (occ.master),
        .food_x     (food_x),
        .food_y     (food_y),
        .food_valid (food_valid),
        .busy       (busy),
        .done       (done),
        .board_full (board_full)
    );

    assign spawn_req = start | noise_spawn;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    int unsigned plist[$];
    qry_t        exp_q[$];
    res_t        res_q[$];
    int          hits_n = 0;
    int          ack_delay = 0;
    bit          consume = 0;

    // Stimulus driver: PRNG stream, occupancy responder and ignored-input noise.
    initial begin
        int idx, qcount, wcnt;
        idx = 0; qcount = 0; wcnt = 0;
        prng_in = '0; occ.occ_ack = 1'b0; occ.occ_hit = 1'b0; noise_spawn = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (rst || !busy) begin
                idx = 0; qcount = 0; wcnt = 0;
            end else if (consume) begin
                idx++;
            end
            prng_in = (idx < plist.size()) ? 16'(plist[idx]) : 16'($urandom);
            if (occ.occ_req) begin
                if (wcnt >= ack_delay) begin
                    occ.occ_ack = 1'b1;
                    occ.occ_hit = (qcount < hits_n);
                    qcount++;
                    wcnt = 0;
                end else begin
                    occ.occ_ack = 1'b0;
                    occ.occ_hit = 1'($urandom);
                    wcnt++;
                end
            end else begin
                occ.occ_ack = ($urandom_range(0, 7) == 0);
                occ.occ_hit = 1'($urandom);
                wcnt = 0;
            end
            noise_spawn = busy && ($urandom_range(0, 3) == 0);
        end
    end

    initial forever begin
        @(negedge clk);
        consume = busy && !occ.occ_req;
    end

    // Monitor: compares each answered query and each final outcome against the scoreboard.
    initial forever begin
        @(negedge clk);
        if (!rst && occ.occ_req && occ.occ_ack) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL query_extra: got (%0d,%0d) expected none", occ.occ_x, occ.occ_y);
            end else begin
                qry_t e;
                e = exp_q.pop_front();
                if (int'(occ.occ_x) != e.x || int'(occ.occ_y) != e.y) begin
                    errors++;
                    $display("FAIL query_xy: got (%0d,%0d) expected (%0d,%0d)",
                             occ.occ_x, occ.occ_y, e.x, e.y);
                end
            end
        end
        if (!rst && (done || board_full)) begin
            checks++;
            if (res_q.size() == 0) begin
                errors++;
                $display("FAIL result_extra: got done=%0d full=%0d expected none", done, board_full);
            end else begin
                res_t r;
                r = res_q.pop_front();
                if (board_full !== r.full || done !== !r.full || food_valid !== !r.full || busy !== 1'b0 ||
                    (!r.full && (int'(food_x) != r.x || int'(food_y) != r.y))) begin
                    errors++;
                    $display("FAIL result: got done=%0d full=%0d valid=%0d busy=%0d food=(%0d,%0d) expected full=%0d food=(%0d,%0d)",
                             done, board_full, food_valid, busy, food_x, food_y, r.full, r.x, r.y);
                end
            end
        end
    end

    function automatic int unsigned rand_valid();
        return $urandom_range(0, 39) + 64 * $urandom_range(0, 29);
    endfunction

    function automatic bit in_grid(input int unsigned v);
        return (v % 64 < 40) && ((v / 64) % 32 < 30);
    endfunction

    // Reference: valid candidates in list order, then linear-index scan over all 1200 cells.
    task automatic build_expect();
        int tries, qn, lx, ly, lin;
        tries = 0; qn = 0; lx = 0; ly = 0;
        foreach (plist[i]) begin
            int x, y;
            x = int'(plist[i] % 64);
            y = int'((plist[i] / 64) % 32);
            if (x >= 40 || y >= 30) continue;
            exp_q.push_back('{x, y});
            if (qn++ >= hits_n) begin
                res_q.push_back('{1'b0, x, y});
                return;
            end
            lx = x; ly = y; tries++;
            if (tries == 8) break;
        end
        lin = ly * 40 + lx;
        for (int k = 0; k < 1200; k++) begin
            lin = (lin + 1) % 1200;
            exp_q.push_back('{lin % 40, lin / 40});
            if (qn++ >= hits_n) begin
                res_q.push_back('{1'b0, lin % 40, lin / 40});
                return;
            end
        end
        res_q.push_back('{1'b1, 0, 0});
    endtask

    task automatic check_bit(input string name, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    task automatic drain();
        bit ok;
        ok = 0;
        for (int c = 0; c < 30000; c++) begin
            @(negedge clk);
            if (res_q.size() == 0 && !busy) begin
                ok = 1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pending results expected 0", res_q.size());
            res_q.delete();
            exp_q.delete();
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queries_left: got %0d unissued expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // lat >= 0: number of SAMPLE cycles expected before the first query (delay 0 only).
    task automatic run_txn(input int hits, input int dly, input int lat);
        hits_n = hits;
        ack_delay = dly;
        build_expect();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        if (lat >= 0) begin
            for (int i = 0; i < lat; i++) begin
                if (i > 0) @(negedge clk);
                check_bit("sample_no_req", occ.occ_req, 1'b0);
            end
            @(negedge clk); check_bit("query_req", occ.occ_req, 1'b1);
            @(negedge clk); check_bit("done_latency", done, 1'b1);
        end
        drain();
    endtask

    task automatic fallback_list(input int unsigned last);
        plist.delete();
        for (int i = 0; i < 7; i++) plist.push_back(rand_valid());
        plist.push_back(last);
    endtask

    initial begin
        int nv;
        int unsigned v;
        rst = 1'b1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_bit("rst_occ_req", occ.occ_req, 1'b0);
        check_bit("rst_busy", busy, 1'b0);
        check_bit("rst_done", done, 1'b0);
        check_bit("rst_board_full", board_full, 1'b0);
        check_bit("rst_food_valid", food_valid, 1'b0);
        check_bit("rst_coords_zero", |{food_x, food_y, occ.occ_x, occ.occ_y}, 1'b0);
        rst = 1'b0;

        plist = '{32'h0145};
        run_txn(0, 0, 1);
        plist = '{32'h003F, 32'h0145};
        run_txn(0, 0, 2);

        fallback_list(32'h0145);
        run_txn(8, 1, -1);
        fallback_list(32'h0767);
        run_txn(8, 0, -1);
        fallback_list(32'h0127);
        run_txn(8, 2, -1);

        // Reset while a query is outstanding.
        plist = '{32'h0145};
        hits_n = 0;
        ack_delay = 6;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int c = 0; c < 20 && !occ.occ_req; c++) @(negedge clk);
        check_bit("query_before_reset", occ.occ_req, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_bit("rst_mid_occ_req", occ.occ_req, 1'b0);
        check_bit("rst_mid_busy", busy, 1'b0);
        check_bit("rst_mid_valid", food_valid, 1'b0);
        check_bit("rst_mid_done", done, 1'b0);
        @(negedge clk);
        check_bit("rst_mid_no_done", done, 1'b0);

        for (int t = 0; t < 25; t++) begin
            plist.delete();
            nv = 0;
            while (nv < 9) begin
                v = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 65535) : rand_valid();
                plist.push_back(v);
                if (in_grid(v)) nv++;
            end
            run_txn($urandom_range(0, 12), $urandom_range(0, 3), -1);
        end

        fallback_list(rand_valid());
        run_txn(100000, 0, -1);
        check_bit("full_valid_low", food_valid, 1'b0);

        plist = '{32'h0145};
        run_txn(0, 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
